// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter granting one of 8 requesters access to a
// shared resource. The grant is presented one-hot and as an encoded index, is
// held until done, requester withdrawal or a hold timeout, and is always
// followed by one idle cycle before the next grant.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,  // forced-release limit in cycles; 0 = no limit
    parameter int CNT_W    = 5    // hold counter width; must be able to hold MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int NUM_REQ = 8;

    // Timeout fires in the cycle the counter reaches MAX_HOLD-1, so a grant
    // stays visible for exactly MAX_HOLD cycles.
    localparam bit               TO_EN     = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = TO_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [2:0]         ptr;       // index searched first on the next grant
    logic [CNT_W-1:0]   hold_cnt;  // cycles the current grant has been visible

    logic [NUM_REQ-1:0] req_rot;   // req rotated so bit 0 is the ptr position
    logic [2:0]         off;       // distance from ptr to the winning requester
    logic               any_req;
    logic [2:0]         win;

    logic               rel_done;
    logic               rel_wdraw;
    logic               rel_to;
    logic               release_now;

    // Rotate the request vector so a plain lowest-bit-first priority encoder
    // implements the round-robin search starting at ptr (3-bit add wraps mod 8).
    genvar j;
    generate
        for (j = 0; j < NUM_REQ; j++) begin : g_rot
            assign req_rot[j] = req[ptr + 3'(j)];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the nearest requester after ptr.
    always_comb begin
        off = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) off = 3'(k);
        end
    end

    assign any_req = |req;
    assign win     = ptr + off;

    // Release causes while BUSY; done and withdrawal take precedence over the
    // timeout so a coincident timeout is not reported.
    assign rel_done    = done;
    assign rel_wdraw   = ~req[grant_id];
    assign rel_to      = TO_EN && (hold_cnt == HOLD_LAST);
    assign release_now = rel_done | rel_wdraw | rel_to;

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (any_req) begin
                        state       <= BUSY;
                        grant       <= 8'b1 << win;
                        grant_id    <= win;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= grant_id + 3'd1;
                        hold_cnt    <= '0;
                        timeout     <= rel_to & ~rel_done & ~rel_wdraw;
                    end else begin
                        timeout <= 1'b0;
                        // Saturate instead of wrapping when there is no limit.
                        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    timeout     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
Round-robin arbiter sharing one downstream resource (e.g. the 8-to-3 encoded datapath slot) among 8 requesters. It grants one requester at a time and presents the grant both one-hot and as a 3-bit encoded index. The grant is held until release, requester withdrawal or a hold timeout. It sits between the requester pool and the shared resource, and the encoded index drives the resource's select/mux.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held before forced release; 0 disables the timeout
CNT_W, 5, width of the hold counter; must hold MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  8  request lines, one per requester, level-sensitive
done  input  1  release strobe from the current grantee; sampled only in BUSY
grant  output  8  one-hot grant; all zero when idle
grant_id  output  3  binary index of the granted requester; valid only while grant_valid=1
grant_valid  output  1  high while a grant is active; equals OR of grant
timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0. Outputs clear immediately without waiting for a clock edge.
- All outputs are registered. No combinational path from req/done to any output.
- State IDLE:
  - If req!=0: search indices ptr, ptr+1, ..., ptr+7 (mod 8) and pick the first set bit w.
  - Next edge: state=BUSY, grant=1<<w, grant_id=w, grant_valid=1, hold_cnt=0.
  - Latency from req sampled in IDLE to grant visible = 1 cycle.
  - If req=0: remain IDLE, outputs unchanged at zero.
- State BUSY: hold_cnt increments each cycle. Release occurs at the edge when any of these holds:
  (a) done=1
  (b) req[grant_id]=0 (requester withdrew)
  (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
- On release, next edge:
  - state=IDLE, grant=0, grant_valid=0, grant_id holds its last value.
  - ptr=(grant_id+1) mod 8.
  - timeout=1 only if (c) is the sole cause.
- timeout is high for exactly one cycle, coincident with the first IDLE cycle.
- Priority of release causes: done and withdrawal suppress timeout. If (a) or (b) coincides with (c), timeout stays 0.
- There is a mandatory one-cycle gap (IDLE) between consecutive grants. The resource sees a clean handover, and grant never changes directly from one one-hot value to another.
- Requests from other requesters during BUSY are ignored and do not preempt the grant.
- done asserted in IDLE is ignored.
- Wrap-around: ptr and the search index are mod 8. After granting requester 7, the next search starts at 0.
- hold_cnt saturates and does not wrap when MAX_HOLD=0.
- grant is always one-hot or zero. Multi-hot grant is illegal, and the bench asserts on it.
- Fairness: with all 8 requests held continuously and done pulsed each grant, grants rotate 0,1,...,7,0 with each requester served once per 8 grants.

Test Plan:
- Reset check: rst_n=0 mid-BUSY with grant=8'b00000100 -> grant=0, grant_valid=0, grant_id=0, timeout=0 immediately. After rst_n=1 and req=8'b00000001 -> grant=8'b00000001 one cycle later.
- Single requester: req=8'b00100000, done pulsed 3 cycles after grant -> grant=8'b00100000 and grant_id=5 for 4 cycles, then grant=0. Next search starts at index 6.
- Round-robin rotation: req=8'hFF held, done pulsed in each BUSY cycle -> grant_id sequence 0,1,2,...,7,0 with one idle cycle between each grant.
- Wrap priority: ptr=6 (after granting 5), req=8'b00000011 -> grant_id=0, not 1. Then ptr=1, and req=8'b00000011 -> grant_id=1.
- Timeout: MAX_HOLD=16, req=8'b10000000 held, done never asserted -> grant held exactly 16 cycles, then grant=0 with timeout=1 for one cycle. Re-grant to 7 follows the idle cycle.
- Simultaneous release: done=1 on the same cycle hold_cnt==MAX_HOLD-1 -> release with timeout=0. Separately, req[grant_id] dropped with req=8'b01000001 (grantee 0) -> grant drops next cycle, then requester 6 is granted after the idle cycle.
